reg_16: RTL and testbench

REG_16 -- requirements
Module: reg_16

---
 rtl/reg_16.sv | 34 +++
 tb/tb_reg_16.sv | 131 +++++++++++++
 2 files changed

// File: rtl/reg_16.sv
// Parallel-load register: loads data_in on a rising clk edge when ld is high,
// otherwise holds; asynchronous active-low reset forces RESET_VALUE.
module reg_16 #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: tb/tb_reg_16.sv
// Self-checking bench for reg_16: directed scenarios with literal expectations
// plus randomized load/hold/reset traffic checked against a last-loaded-value model.
module tb_reg_16;

  localparam int unsigned W      = 16;
  localparam logic [W-1:0] RSTV  = 16'h0000;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] data_in;
  logic [W-1:0] q;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: q is the most recent value loaded since the last reset, else RSTV.
  logic [W-1:0] exp_q;
  logic         chk_en = 1'b0;

  reg_16 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .data_in (data_in),
    .q       (q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: q=%h expected=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #3;
    if (chk_en) check("cycle", q, exp_q);
  end

  // Inputs change on the falling edge; model advances just after the rising edge.
  task automatic drive(input logic r, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; ld = l; data_in = d;
    if (!r) exp_q = RSTV;
    @(posedge clk);
    #1;
    if (r && l) exp_q = d;
  endtask

  initial begin
    logic         r, l;
    logic [W-1:0] d;

    rst = 1'b1; ld = 1'b1; data_in = 16'hFFFF;
    #1;
    rst = 1'b0;
    #1;
    check("reset_async", q, 16'h0000);
    exp_q  = RSTV;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hFFFF);
    check("reset_hold", q, 16'h0000);

    drive(1'b1, 1'b1, 16'h0005);
    check("basic_load", q, 16'h0005);
    drive(1'b1, 1'b0, 16'h0008);
    drive(1'b1, 1'b0, 16'h0008);
    check("hold", q, 16'h0005);
    drive(1'b1, 1'b1, 16'h0008);
    check("reload", q, 16'h0008);

    drive(1'b1, 1'b1, 16'hA5A5);
    check("load_a5a5", q, 16'hA5A5);
    #4;
    ld = 1'b0;
    rst = 1'b0;
    exp_q = RSTV;
    #1;
    check("midcycle_reset", q, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check("reset_release", q, 16'h0000);
    drive(1'b1, 1'b0, 16'h1234);
    check("post_reset_hold", q, 16'h0000);

    drive(1'b1, 1'b1, 16'hFFFF);
    check("load_ffff", q, 16'hFFFF);
    drive(1'b1, 1'b1, 16'h8001);
    check("load_8001", q, 16'h8001);
    drive(1'b1, 1'b1, 16'h0000);
    check("load_0000", q, 16'h0000);
    drive(1'b1, 1'b1, 16'h7FFE);
    check("load_7ffe", q, 16'h7FFE);

    // Reset asserted in the same timestep as a loading edge.
    @(negedge clk);
    rst = 1'b1; ld = 1'b1; data_in = 16'h1234;
    @(posedge clk);
    rst = 1'b0;
    exp_q = RSTV;
    #1;
    check("reset_vs_load", q, 16'h0000);
    drive(1'b1, 1'b0, 16'h4321);
    check("reset_win_hold", q, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) != 0);
      l = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       d = 16'hFFFF;
        1:       d = 16'h0000;
        2:       d = 16'h8001;
        default: d = 16'($urandom);
      endcase
      drive(r, l, d);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
